// File: rtl/cursor_select_ctrl.sv
// cursor_select_ctrl: button conditioning (sync, debounce, auto-repeat), cursor movement and select/target FSM.
// Build option: define CURSOR_WRAP_EN to wrap the cursor at board edges instead of saturating.
module cursor_select_ctrl #(
  parameter int BOARD_DIM       = 8,
  parameter int LOC_W           = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_btn_up,
  input  logic             in_btn_down,
  input  logic             in_btn_left,
  input  logic             in_btn_right,
  input  logic             in_selected,
  input  logic             move_ack,
  output logic [LOC_W-1:0] location,
  output logic [LOC_W-1:0] sel_loc,
  output logic             sel_valid,
  output logic             move_valid,
  output logic [LOC_W-1:0] move_from,
  output logic [LOC_W-1:0] move_to
);

  localparam int NBTN   = 5;
  localparam int NDIR   = 4;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0]  DELAY_L  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0]  RATE_L   = RP_W'(REPEAT_RATE);
  localparam logic [RP_W-1:0]  RP_MAX_L = RP_W'(RP_MAX);
  localparam logic             REP_EN   = (REPEAT_DELAY != 0) ? 1'b1 : 1'b0;
  localparam logic [LOC_W-1:0] ZERO_L   = {LOC_W{1'b0}};
  localparam logic [LOC_W-1:0] ONE_L    = LOC_W'(1'b1);
  localparam logic [LOC_W-1:0] DIM_L    = LOC_W'(BOARD_DIM);
  localparam logic [LOC_W-1:0] LAST_L   = LOC_W'(BOARD_DIM - 1);
  localparam logic [LOC_W-1:0] SPAN_L   = LOC_W'(BOARD_DIM * (BOARD_DIM - 1));
`ifdef CURSOR_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, PICKED = 2'd1, PENDING = 2'd2} state_t;

  // Button index: 0 up, 1 down, 2 left, 3 right, 4 select
  logic [NBTN-1:0]  raw_s, sync1_r, sync2_r, level_r, level_d_r, press_s;
  logic [DB_W-1:0]  db_cnt_r [NBTN];
  logic [RP_W-1:0]  rep_cnt_r [NDIR];
  logic [NDIR-1:0]  rep_phase_r, rep_s, dir_s;
  logic             sel_ev_s;
  logic [LOC_W-1:0] row_s, col_s, loc_nxt_s;
  state_t           state_r, state_nxt_s;
  logic [LOC_W-1:0] location_r, sel_loc_r, move_from_r, move_to_r;
  logic [LOC_W-1:0] sel_loc_nxt_s, move_from_nxt_s, move_to_nxt_s;
  logic             sel_valid_r, move_valid_r, sel_valid_nxt_s, move_valid_nxt_s;

  assign raw_s = {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up};

  // Synchroniser, debounce counters and press-edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      level_r   <= '0;
      level_d_r <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_r[i] <= '0;
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          level_r[i]  <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1'b1);
        end
      end
    end
  end

  assign press_s = level_r & ~level_d_r;

  // Repeat fires when the cycles since the last event reach the current interval
  always_comb begin
    rep_s = '0;
    for (int i = 0; i < NDIR; i++) begin
      rep_s[i] = REP_EN & level_r[i] & (rep_cnt_r[i] == (rep_phase_r[i] ? RATE_L : DELAY_L));
    end
  end

  // Auto-repeat counters: count cycles since the last press/repeat while held
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_phase_r <= '0;
      for (int i = 0; i < NDIR; i++) rep_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        if (!level_r[i]) begin
          rep_cnt_r[i]   <= '0;
          rep_phase_r[i] <= 1'b0;
        end else if (press_s[i] || rep_s[i]) begin
          rep_cnt_r[i]   <= RP_W'(1'b1);
          rep_phase_r[i] <= rep_s[i];
        end else if (rep_cnt_r[i] != RP_MAX_L) begin
          rep_cnt_r[i]   <= rep_cnt_r[i] + RP_W'(1'b1);
        end else begin
          rep_cnt_r[i]   <= rep_cnt_r[i];
        end
      end
    end
  end

  assign dir_s    = press_s[NDIR-1:0] | rep_s;
  assign sel_ev_s = press_s[4];
  assign row_s    = location_r / DIM_L;
  assign col_s    = location_r % DIM_L;

  // Cursor next location, one move per cycle, up > down > left > right
  always_comb begin
    loc_nxt_s = location_r;
    if (dir_s[0]) begin
      if (row_s != ZERO_L) loc_nxt_s = location_r - DIM_L;
      else if (WRAP_EN)    loc_nxt_s = location_r + SPAN_L;
      else                 loc_nxt_s = location_r;
    end else if (dir_s[1]) begin
      if (row_s != LAST_L) loc_nxt_s = location_r + DIM_L;
      else if (WRAP_EN)    loc_nxt_s = location_r - SPAN_L;
      else                 loc_nxt_s = location_r;
    end else if (dir_s[2]) begin
      if (col_s != ZERO_L) loc_nxt_s = location_r - ONE_L;
      else if (WRAP_EN)    loc_nxt_s = location_r + LAST_L;
      else                 loc_nxt_s = location_r;
    end else if (dir_s[3]) begin
      if (col_s != LAST_L) loc_nxt_s = location_r + ONE_L;
      else if (WRAP_EN)    loc_nxt_s = location_r - LAST_L;
      else                 loc_nxt_s = location_r;
    end else begin
      loc_nxt_s = location_r;
    end
  end

  // Selection FSM next state; decisions use the pre-move cursor location
  always_comb begin
    state_nxt_s      = state_r;
    sel_loc_nxt_s    = sel_loc_r;
    sel_valid_nxt_s  = sel_valid_r;
    move_valid_nxt_s = move_valid_r;
    move_from_nxt_s  = move_from_r;
    move_to_nxt_s    = move_to_r;
    case (state_r)
      IDLE: begin
        if (sel_ev_s) begin
          sel_loc_nxt_s   = location_r;
          sel_valid_nxt_s = 1'b1;
          state_nxt_s     = PICKED;
        end else begin
          state_nxt_s     = IDLE;
        end
      end
      PICKED: begin
        if (sel_ev_s && (location_r == sel_loc_r)) begin
          sel_valid_nxt_s  = 1'b0;
          state_nxt_s      = IDLE;
        end else if (sel_ev_s) begin
          move_from_nxt_s  = sel_loc_r;
          move_to_nxt_s    = location_r;
          move_valid_nxt_s = 1'b1;
          state_nxt_s      = PENDING;
        end else begin
          state_nxt_s      = PICKED;
        end
      end
      PENDING: begin
        if (move_ack) begin
          move_valid_nxt_s = 1'b0;
          sel_valid_nxt_s  = 1'b0;
          state_nxt_s      = IDLE;
        end else begin
          state_nxt_s      = PENDING;
        end
      end
      default: begin
        move_valid_nxt_s = 1'b0;
        sel_valid_nxt_s  = 1'b0;
        state_nxt_s      = IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      location_r   <= '0;
      sel_loc_r    <= '0;
      sel_valid_r  <= 1'b0;
      move_valid_r <= 1'b0;
      move_from_r  <= '0;
      move_to_r    <= '0;
    end else begin
      state_r      <= state_nxt_s;
      location_r   <= loc_nxt_s;
      sel_loc_r    <= sel_loc_nxt_s;
      sel_valid_r  <= sel_valid_nxt_s;
      move_valid_r <= move_valid_nxt_s;
      move_from_r  <= move_from_nxt_s;
      move_to_r    <= move_to_nxt_s;
    end
  end

  assign location   = location_r;
  assign sel_loc    = sel_loc_r;
  assign sel_valid  = sel_valid_r;
  assign move_valid = move_valid_r;
  assign move_from  = move_from_r;
  assign move_to    = move_to_r;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Scoreboard bench for cursor_select_ctrl: expected output bundles with their edge numbers are queued
// by the stimulus; a negedge monitor pops one entry on every observed output change.
module tb_cursor_select_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_btn_up = 1'b0, in_btn_down = 1'b0, in_btn_left = 1'b0, in_btn_right = 1'b0;
  logic       in_selected = 1'b0, move_ack = 1'b0;
  logic [5:0] location, sel_loc, move_from, move_to;
  logic       sel_valid, move_valid;

  cursor_select_ctrl #(
    .BOARD_DIM(8), .LOC_W(6), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .rst(rst),
    .in_btn_up(in_btn_up), .in_btn_down(in_btn_down), .in_btn_left(in_btn_left),
    .in_btn_right(in_btn_right), .in_selected(in_selected), .move_ack(move_ack),
    .location(location), .sel_loc(sel_loc), .sel_valid(sel_valid),
    .move_valid(move_valid), .move_from(move_from), .move_to(move_to)
  );

  always #5 clk = ~clk;

  // Bundle: {location, sel_loc, sel_valid, move_valid, move_from, move_to}
  typedef struct {
    int          e;
    logic [25:0] b;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [25:0] last_b;
  logic [25:0] cur_b;

  localparam logic [4:0] UP = 5'b00001, DOWN = 5'b00010, LEFT = 5'b00100, RIGHT = 5'b01000, SEL = 5'b10000;

  assign cur_b = {location, sel_loc, sel_valid, move_valid, move_from, move_to};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [25:0] pk(input logic [5:0] loc, input logic [5:0] sl, input logic sv,
                                     input logic mv, input logic [5:0] frm, input logic [5:0] to);
    return {loc, sl, sv, mv, frm, to};
  endfunction

  task automatic expect_at(input int e, input logic [5:0] loc, input logic [5:0] sl, input logic sv,
                           input logic mv, input logic [5:0] frm, input logic [5:0] to);
    exp_t x;
    x.e = e;
    x.b = pk(loc, sl, sv, mv, frm, to);
    q.push_back(x);
  endtask

  task automatic tap(input logic [4:0] m, input int hold);
    {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up} = m;
    repeat (hold) @(negedge clk);
    {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up} = 5'b00000;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ack();
    move_ack = 1'b1;
    @(negedge clk);
    move_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [25:0] want);
    n_vec++;
    if (cur_b !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, cur_b, want);
    end
  endtask

  // Monitor: every output change must match the next queued bundle at the queued edge
  always @(negedge clk) begin
    if (mon_en && (cur_b !== last_b)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%h want=no_change", cyc, cur_b);
      end else begin
        exp_t x;
        x = q.pop_front();
        if ((x.b !== cur_b) || (x.e != cyc)) begin
          n_err++;
          $display("FAIL output_change cyc=%0d got=%h want=%h at edge %0d", cyc, cur_b, x.b, x.e);
        end
      end
      last_b = cur_b;
    end
  end

  initial begin
    // Reset over edges 1..3
    while (cyc < 3) @(negedge clk);
    rst = 1'b0;
    check_now("reset_state", pk(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0));
    last_b = cur_b;
    mon_en = 1'b1;

    // Latency: right held from edge 10 moves at edge 17, no repeat before release
    while (cyc < 10) @(negedge clk);
    expect_at(17, 6'd1, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    tap(RIGHT, 8);

    // Glitch rejection on down
    for (int i = 0; i < 5; i++) begin
      in_btn_down = 1'b1;
      repeat (3) @(negedge clk);
      in_btn_down = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_now("glitch_reject", pk(6'd1, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0));

    expect_at(cyc + 7, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    tap(LEFT, 6);

    // Up from row 0
`ifdef CURSOR_WRAP_EN
    expect_at(cyc + 7, 6'd56, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    tap(UP, 6);
    expect_at(cyc + 7, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    tap(DOWN, 6);
`else
    tap(UP, 6);
`endif
    check_now("edge_up", pk(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0));

    // Auto-repeat: press, +10, then every 5, saturating at col 7
    begin
      int b;
      b = cyc;
      expect_at(b + 7,  6'd1, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      expect_at(b + 17, 6'd2, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      expect_at(b + 22, 6'd3, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      expect_at(b + 27, 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      expect_at(b + 32, 6'd5, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      expect_at(b + 37, 6'd6, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      expect_at(b + 42, 6'd7, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
      tap(RIGHT, 47);
    end
    check_now("repeat_saturate", pk(6'd7, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0));

    // Right from col 7
`ifdef CURSOR_WRAP_EN
    expect_at(cyc + 7, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    tap(RIGHT, 6);
    expect_at(cyc + 7, 6'd7, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    tap(LEFT, 6);
`else
    tap(RIGHT, 6);
`endif
    check_now("edge_right", pk(6'd7, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0));

    // Reset returns cursor to 0
    expect_at(cyc + 1, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    pulse_rst();

    // Select at 9, target 18
    expect_at(cyc + 7, 6'd8,  6'd0, 1'b0, 1'b0, 6'd0, 6'd0);  tap(DOWN, 6);
    expect_at(cyc + 7, 6'd9,  6'd0, 1'b0, 1'b0, 6'd0, 6'd0);  tap(RIGHT, 6);
    expect_at(cyc + 7, 6'd9,  6'd9, 1'b1, 1'b0, 6'd0, 6'd0);  tap(SEL, 6);
    expect_at(cyc + 7, 6'd17, 6'd9, 1'b1, 1'b0, 6'd0, 6'd0);  tap(DOWN, 6);
    expect_at(cyc + 7, 6'd18, 6'd9, 1'b1, 1'b0, 6'd0, 6'd0);  tap(RIGHT, 6);
    expect_at(cyc + 7, 6'd18, 6'd9, 1'b1, 1'b1, 6'd9, 6'd18); tap(SEL, 6);

    // Pending: cursor still moves, select ignored
    expect_at(cyc + 7, 6'd26, 6'd9, 1'b1, 1'b1, 6'd9, 6'd18); tap(DOWN, 6);
    expect_at(cyc + 7, 6'd27, 6'd9, 1'b1, 1'b1, 6'd9, 6'd18); tap(RIGHT, 6);
    tap(SEL, 6);
    check_now("pending_select_ignored", pk(6'd27, 6'd9, 1'b1, 1'b1, 6'd9, 6'd18));

    expect_at(cyc + 1, 6'd27, 6'd9, 1'b0, 1'b0, 6'd9, 6'd18);
    pulse_ack();

    // Up beats left in the same cycle
    expect_at(cyc + 7, 6'd19, 6'd9, 1'b0, 1'b0, 6'd9, 6'd18); tap(UP | LEFT, 6);
    expect_at(cyc + 7, 6'd11, 6'd9, 1'b0, 1'b0, 6'd9, 6'd18); tap(UP, 6);
    expect_at(cyc + 7, 6'd10, 6'd9, 1'b0, 1'b0, 6'd9, 6'd18); tap(LEFT, 6);
    expect_at(cyc + 7, 6'd9,  6'd9, 1'b0, 1'b0, 6'd9, 6'd18); tap(LEFT, 6);

    // Select then deselect at 9
    expect_at(cyc + 7, 6'd9, 6'd9, 1'b1, 1'b0, 6'd9, 6'd18); tap(SEL, 6);
    expect_at(cyc + 7, 6'd9, 6'd9, 1'b0, 1'b0, 6'd9, 6'd18); tap(SEL, 6);

    // Simultaneous move + select uses pre-move location as target
    expect_at(cyc + 7, 6'd9,  6'd9, 1'b1, 1'b0, 6'd9, 6'd18); tap(SEL, 6);
    expect_at(cyc + 7, 6'd10, 6'd9, 1'b1, 1'b0, 6'd9, 6'd18); tap(RIGHT, 6);
    expect_at(cyc + 7, 6'd11, 6'd9, 1'b1, 1'b1, 6'd9, 6'd10); tap(RIGHT | SEL, 6);

    // Reset while pending drops everything
    expect_at(cyc + 1, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    pulse_rst();
    repeat (20) @(negedge clk);

    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL missing_changes cyc=%0d got=%0d pending want=0", cyc, q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cursor_select_ctrl.md
Name: cursor_select_ctrl

Overview:
- Parametrised next-generation cursor/selection controller for the board game.
- Sits between the raw push-buttons and the game_logic/display blocks.
- Synchronises and debounces the five buttons, with auto-repeat on the four direction buttons.
- Moves a cursor over an N×N board and runs a select/target state machine.
- Hands completed moves to game logic through a valid/ack handshake.

Parameters:
- BOARD_DIM, 8: squares per side; location = row*BOARD_DIM + col, row 0 = top, col 0 = left.
- LOC_W, 6: location width; must be ≥ clog2(BOARD_DIM*BOARD_DIM).
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles before a debounced level changes; must be ≥1.
- REPEAT_DELAY, 12500000: held cycles after a direction press before the first repeat; 0 disables auto-repeat.
- REPEAT_RATE, 5000000: cycles between subsequent repeats; must be ≥1.

Ports:
- clk  in  1  system clock (25 MHz domain)
- rst  in  1  synchronous reset, active-high
- in_btn_up  in  1  raw up button, active-high, asynchronous to clk
- in_btn_down  in  1  raw down button
- in_btn_left  in  1  raw left button
- in_btn_right  in  1  raw right button
- in_selected  in  1  raw select button
- move_ack  in  1  game logic accepts move_from/move_to
- location  out  LOC_W  cursor location
- sel_loc  out  LOC_W  selected piece location
- sel_valid  out  1  sel_loc holds a live selection
- move_valid  out  1  move request pending
- move_from  out  LOC_W  source square of the pending move
- move_to  out  LOC_W  target square of the pending move

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0. State = IDLE. Synchronisers, debounce counters and repeat counters all 0.
- Input conditioning: each button passes a 2-flop synchroniser, then a debouncer.
  - Debounced level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreement clears that button's counter.
- Press event: 1-cycle pulse on a debounced 0→1 edge. Its registered effect appears on the next edge.
- Latency: a clean raw rise held from edge k updates location at edge k+DEBOUNCE_CYCLES+3.
- Auto-repeat (direction buttons only, REPEAT_DELAY≠0):
  - While the debounced level stays high, one repeat event fires REPEAT_DELAY cycles after the press event.
  - Further repeats fire every REPEAT_RATE cycles after that.
  - Release clears the repeat counter.
  - The select button never repeats.
- Cursor movement:
  - At most one move per cycle. Priority up > down > left > right; lower-priority events in the same cycle are discarded.
  - up: row-1. down: row+1. left: col-1. right: col+1.
  - Edge behaviour depends on CURSOR_WRAP_EN (see Optional Feature).
  - Cursor movement is permitted in every state.
- Selection FSM:
  - IDLE: select event → sel_loc=location, sel_valid=1, go to PICKED.
  - PICKED, select at location==sel_loc: sel_valid=0, go to IDLE (deselect).
  - PICKED, select at location≠sel_loc: move_from=sel_loc, move_to=location, move_valid=1, go to PENDING.
  - PENDING: select events ignored. move_from, move_to and sel_loc are held stable.
  - PENDING, move_ack=1 on an edge: move_valid=0, sel_valid=0, go to IDLE on that same edge.
  - move_ack while not PENDING is ignored.
- Simultaneous direction + select in one cycle: the cursor move and the FSM action both occur. The FSM uses the pre-move location.
- rst mid-operation: a pending move is dropped (move_valid→0) and the cursor returns to 0.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: moves off an edge wrap within the same row or column.
  - up from row 0 → row BOARD_DIM-1.
  - right from col BOARD_DIM-1 → col 0.
- Undefined: moves saturate at the board edge and location is unchanged.
- All other behaviour is identical.

Test Plan:
- Debounce and latency. Setup: BOARD_DIM=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=0. Stimulus: rst, then in_btn_right held from edge 10. Required: location 0→1 exactly at edge 17, and no further change while held.
- Glitch rejection. Stimulus: in_btn_down high for 3 cycles, low, repeated 5 times (DEBOUNCE_CYCLES=4). Required: location stays 0.
- Auto-repeat. Setup: REPEAT_DELAY=10, REPEAT_RATE=5. Stimulus: hold right for 40 cycles after the press event. Required: location 1 at the press, 2 after +10 cycles, then 3, 4, 5, 6, 7 at +5-cycle intervals; later events saturate at 7 (wrap off).
- Edge behaviour. Stimulus: press up at location 0. Required: location=0 with wrap off; location=56 with CURSOR_WRAP_EN. Likewise right at 7: stays 7 with wrap off, becomes 0 with wrap on.
- Move handshake, part 1. Stimulus: select at 9, move cursor to 18, select. Required: sel_loc=9, sel_valid=1, then move_valid=1, move_from=9, move_to=18.
- Move handshake, part 2. Stimulus: while PENDING, press select at 27. Required: outputs unchanged. Stimulus: move_ack pulse. Required: move_valid=0 and sel_valid=0 on that edge. Stimulus: select at 9 again, then select at 9 once more. Required: sel_valid=0 (deselect).
- Priority and reset. Stimulus: up and left press events in the same cycle at location 27. Required: location=19. Stimulus: rst during PENDING. Required: all outputs 0 on the next edge.
